// File: rtl/des_key_schedule.sv
// des_key_schedule: iterative DES key schedule. One PC-1 load on start, then
// one subkey per valid/ready transfer, in K1..K16 or K16..K1 order. An
// optional 16x48 table keeps the subkeys for random access by keyid.
//
// Stream handshake: sk_valid/sk_data/sk_id are register outputs; a subkey
// transfers on a rising clk edge where sk_valid && sk_ready. While sk_ready
// is low the presented subkey and its id are held unchanged.
module des_key_schedule #(
    parameter logic [15:0] ONE_SHIFT_MASK = 16'h8103,
    parameter int          KEY_TABLE      = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [1:64] keyIn,
    output logic        busy,
    output logic        sk_valid,
    input  logic        sk_ready,
    output logic [1:48] sk_data,
    output logic [5:0]  sk_id,
    output logic        done,
    input  logic [5:0]  keyid,
    output logic [1:48] rd_subkey,
    output logic        table_valid,
    output logic        dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int PC1_TBL [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TBL [0:47] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    function automatic logic [1:56] pc1(input logic [1:64] k);
        logic [1:56] r;
        r = '0;
        for (int j = 0; j < 56; j++) begin
            r[j + 1] = k[PC1_TBL[j]];
        end
        return r;
    endfunction

    function automatic logic [1:48] pc2(input logic [1:56] cd);
        logic [1:48] r;
        r = '0;
        for (int j = 0; j < 48; j++) begin
            r[j + 1] = cd[PC2_TBL[j]];
        end
        return r;
    endfunction

    // Bit 1 is the MSB, so a left rotation moves bits toward index 1.
    function automatic logic [1:28] rot(input logic [1:28] x, input logic one, input logic left);
        logic [1:28] r;
        if (left) begin
            r = one ? {x[2:28], x[1]} : {x[3:28], x[1:2]};
        end else begin
            r = one ? {x[28], x[1:27]} : {x[27:28], x[1:26]};
        end
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [1:28] c_q, c_d;
    logic [1:28] d_q, d_d;
    logic [5:0]  sk_id_q, sk_id_d;
    logic [1:48] sk_data_q, sk_data_d;
    logic        dec_q, dec_d;
    logic        done_q, done_d;

    logic [1:56] key_cd;
    logic        accept;
    logic        xfer;
    logic        last_xfer;
    logic [3:0]  sh_idx;
    logic        sh_one;

    assign key_cd    = pc1(keyIn);
    assign accept    = (state_q == IDLE) && start;
    assign xfer      = (state_q == RUN) && sk_ready;
    assign last_xfer = xfer && (dec_q ? (sk_id_q == 6'd1) : (sk_id_q == 6'd16));

    // Shift for the next step: encrypt uses s(id+1) = mask[id]; decrypt undoes
    // s(id) = mask[id-1]. At id=16 the 4-bit decrement wraps to 15 as needed.
    assign sh_idx = dec_q ? (sk_id_q[3:0] - 4'd1) : sk_id_q[3:0];
    assign sh_one = ONE_SHIFT_MASK[sh_idx];

    // Next-state logic for the schedule FSM and the C/D working registers.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        sk_id_d = sk_id_q;
        dec_d   = dec_q;
        done_d  = 1'b0;
        if (accept) begin
            dec_d   = decrypt;
            state_d = RUN;
            if (decrypt) begin
                // Full rotation totals 28, so the unrotated halves are C16/D16.
                c_d     = key_cd[1:28];
                d_d     = key_cd[29:56];
                sk_id_d = 6'd16;
            end else begin
                c_d     = rot(key_cd[1:28], ONE_SHIFT_MASK[0], 1'b1);
                d_d     = rot(key_cd[29:56], ONE_SHIFT_MASK[0], 1'b1);
                sk_id_d = 6'd1;
            end
        end else if (xfer) begin
            if (last_xfer) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else if (dec_q) begin
                c_d     = rot(c_q, sh_one, 1'b0);
                d_d     = rot(d_q, sh_one, 1'b0);
                sk_id_d = sk_id_q - 6'd1;
            end else begin
                c_d     = rot(c_q, sh_one, 1'b1);
                d_d     = rot(d_q, sh_one, 1'b1);
                sk_id_d = sk_id_q + 6'd1;
            end
        end
        sk_data_d = pc2({c_d, d_d});
    end

    // Schedule state and registered stream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            c_q       <= '0;
            d_q       <= '0;
            sk_id_q   <= '0;
            sk_data_q <= '0;
            dec_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            d_q       <= d_d;
            sk_id_q   <= sk_id_d;
            sk_data_q <= sk_data_d;
            dec_q     <= dec_d;
            done_q    <= done_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign sk_valid  = (state_q == RUN);
    assign sk_data   = sk_data_q;
    assign sk_id     = sk_id_q;
    assign done      = done_q;
    assign dbg_state = state_q;

    if (KEY_TABLE != 0) begin : g_table
        logic [1:48] tbl_q [1:16];
        logic [1:48] tbl_d [1:16];
        logic        tv_q, tv_d;
        logic [1:48] rd_val;

        // Capture each transferred subkey at its round index; track freshness.
        always_comb begin
            tbl_d = tbl_q;
            tv_d  = tv_q;
            if (accept) begin
                tv_d = 1'b0;
            end
            for (int i = 1; i <= 16; i++) begin
                if (xfer && (sk_id_q == 6'(i))) begin
                    tbl_d[i] = sk_data_q;
                end
            end
            if (last_xfer) begin
                tv_d = 1'b1;
            end
        end

        // Table storage, cleared by reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 1; i <= 16; i++) begin
                    tbl_q[i] <= '0;
                end
                tv_q <= 1'b0;
            end else begin
                tbl_q <= tbl_d;
                tv_q  <= tv_d;
            end
        end

        // Combinational read; out-of-range keyid returns zero.
        always_comb begin
            rd_val = '0;
            for (int i = 1; i <= 16; i++) begin
                if (keyid == 6'(i)) begin
                    rd_val = tbl_q[i];
                end
            end
        end

        assign rd_subkey   = rd_val;
        assign table_valid = tv_q;
    end else begin : g_no_table
        assign rd_subkey   = '0;
        assign table_valid = 1'b0;
    end

endmodule
